button_led_ctrl: RTL

BUTTON_LED_CTRL -- requirements
Module: button_led_ctrl

---
 rtl/btn_led_pkg.sv | 25 ++
 rtl/button_led_ctrl_if.sv | 21 ++
 rtl/debounce_sync.sv | 51 +++++
 rtl/button_led_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/btn_led_pkg.sv
// Shared definitions for the button/switch LED controller: FSM encodings,
// Grant bit positions and counter sizing.
package btn_led_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'b00;
  localparam state_t StBtn  = 2'b01;
  localparam state_t StSw   = 2'b10;

  localparam int unsigned GrantBtnIdx = 0;
  localparam int unsigned GrantSwIdx  = 1;

  // Wide enough for the largest DEBOUNCE_CYCLES / BLINK_HALF (65535).
  localparam int unsigned CntWidth = 16;

  function automatic logic [1:0] grant_of(state_t st);
    logic [1:0] g;
    g = 2'b00;
    if (st == StBtn) g[GrantBtnIdx] = 1'b1;
    if (st == StSw)  g[GrantSwIdx]  = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/button_led_ctrl_if.sv
// Pin bundle between the controller and its board-level environment.
interface button_led_ctrl_if;

  logic       Button;
  logic       Switch;
  logic       LED_B;
  logic       LED_S;
  logic [1:0] Grant;
  logic [7:0] Press_Count;

  modport master (
    output Button, Switch,
    input  LED_B, LED_S, Grant, Press_Count
  );

  modport slave (
    input  Button, Switch,
    output LED_B, LED_S, Grant, Press_Count
  );

endinterface

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a stability-count debouncer for one raw input.
module debounce_sync
  import btn_led_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic din_i,
  output logic db_o
);

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(DEBOUNCE_CYCLES - 1);

  logic                sync1_q;
  logic                sync2_q;
  logic                db_q;
  logic                db_d;
  logic [CntWidth-1:0] cnt_q;
  logic [CntWidth-1:0] cnt_d;

  // Counter only survives consecutive disagreeing cycles; any agreement clears it.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CntMax) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/button_led_ctrl.sv
// Arbitrates two debounced inputs onto LED indicators: Button preempts Switch,
// Switch ownership blinks LED_S, and accepted Button presses are counted.
module button_led_ctrl
  import btn_led_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned BLINK_HALF      = 8
) (
  input logic                Clk,
  input logic                Rst_n,
  button_led_ctrl_if.slave   bus
);

  localparam logic [CntWidth-1:0] BlinkMax = CntWidth'(BLINK_HALF - 1);

  logic                btn_db;
  logic                sw_db;
  logic                btn_db_prev_q;
  state_t              state_q;
  state_t              state_d;
  logic                led_b_q;
  logic                led_s_q;
  logic                led_s_d;
  logic [1:0]          grant_q;
  logic [7:0]          press_cnt_q;
  logic [7:0]          press_cnt_d;
  logic [CntWidth-1:0] blink_q;
  logic [CntWidth-1:0] blink_d;

  debounce_sync #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_db (
    .clk_i (Clk),
    .rst_ni(Rst_n),
    .din_i (bus.Button),
    .db_o  (btn_db)
  );

  debounce_sync #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_db (
    .clk_i (Clk),
    .rst_ni(Rst_n),
    .din_i (bus.Switch),
    .db_o  (sw_db)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (btn_db)     state_d = StBtn;
        else if (sw_db) state_d = StSw;
      end
      StBtn: begin
        if (!btn_db) state_d = sw_db ? StSw : StIdle;
      end
      StSw: begin
        if (btn_db)      state_d = StBtn;
        else if (!sw_db) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Blink phase restarts at 1 on every entry into StSw; LED_S is dark elsewhere.
  always_comb begin
    led_s_d = 1'b0;
    blink_d = '0;
    if (state_d == StSw) begin
      if (state_q != StSw) begin
        led_s_d = 1'b1;
      end else if (blink_q == BlinkMax) begin
        led_s_d = ~led_s_q;
      end else begin
        led_s_d = led_s_q;
        blink_d = blink_q + CntWidth'(1);
      end
    end
  end

  always_comb begin
    press_cnt_d = press_cnt_q;
    if (btn_db && !btn_db_prev_q) press_cnt_d = press_cnt_q + 8'd1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= StIdle;
      led_b_q       <= 1'b0;
      led_s_q       <= 1'b0;
      grant_q       <= 2'b00;
      blink_q       <= '0;
      press_cnt_q   <= 8'd0;
      btn_db_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      led_b_q       <= (state_d == StBtn);
      led_s_q       <= led_s_d;
      grant_q       <= grant_of(state_d);
      blink_q       <= blink_d;
      press_cnt_q   <= press_cnt_d;
      btn_db_prev_q <= btn_db;
    end
  end

  assign bus.LED_B       = led_b_q;
  assign bus.LED_S       = led_s_q;
  assign bus.Grant       = grant_q;
  assign bus.Press_Count = press_cnt_q;

  a_grant_onehot0: assert property (@(posedge Clk) disable iff (!Rst_n) $onehot0(grant_q));
  a_leds_exclusive: assert property (@(posedge Clk) disable iff (!Rst_n) !(led_b_q && led_s_q));
  a_state_legal: assert property (@(posedge Clk) disable iff (!Rst_n) state_q != 2'b11);

endmodule
